// File: rtl/collision_map_writer.sv
// collision_map_writer: writer side of the 1-bit collision RAM.
// It zeroes the whole map on request. It also rasterises clipped rectangle
// descriptors into the map, one write per sys_clk. The read side uses
// addr = x + y*MAP_W.
// Optional build macro CMAP_BORDER_EN: the clear also draws the side walls
// and the floor (x==0, x==MAP_W-1, y==MAP_H-1).
module collision_map_writer #(
  parameter int MAP_W  = 960,
  parameter int MAP_H  = 512,
  parameter int ADDR_W = 20
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              clear_start,
  input  logic              rect_valid,
  output logic              rect_ready,
  input  logic [9:0]        rect_x0,
  input  logic [9:0]        rect_y0,
  input  logic [9:0]        rect_x1,
  input  logic [9:0]        rect_y1,
  input  logic              rect_solid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_din,
  output logic              busy,
  output logic              done,
  output logic              rect_err
);

  typedef enum logic [1:0] {IDLE, CLEAR, FILL} state_t;

  localparam logic [9:0]        X_MAX  = 10'(MAP_W - 1);
  localparam logic [9:0]        Y_MAX  = 10'(MAP_H - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(MAP_W);

  state_t              state, state_nxt;
  logic [9:0]          x0_q, x1_q, y1_q, x_q, y_q;
  logic [9:0]          x0_nxt, x1_nxt, y1_nxt, x_nxt, y_nxt;
  logic [ADDR_W-1:0]   row_base_q, row_base_nxt;
  logic                solid_q, solid_nxt;
  logic                we_nxt, din_nxt, busy_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [9:0]          x1_clip, y1_clip;
  logic                rect_empty, accept, last_cell;

  assign rect_ready = (state == IDLE) & ~clear_start & ~rst;
  assign accept     = rect_valid & rect_ready;
  assign x1_clip    = (rect_x1 > X_MAX) ? X_MAX : rect_x1;
  assign y1_clip    = (rect_y1 > Y_MAX) ? Y_MAX : rect_y1;
  assign rect_empty = (rect_x0 > x1_clip) | (rect_y0 > y1_clip);
  assign last_cell  = (x_q == x1_q) & (y_q == y1_q);

  // Next-state, walk counters and next output values.
  // CLEAR reuses the FILL walker with the bounds set to the full map.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_nxt    = state;
    x0_nxt       = x0_q;
    x1_nxt       = x1_q;
    y1_nxt       = y1_q;
    x_nxt        = x_q;
    y_nxt        = y_q;
    row_base_nxt = row_base_q;
    solid_nxt    = solid_q;
    we_nxt       = 1'b0;
    addr_nxt     = ram_addr;
    din_nxt      = ram_din;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (clear_start) begin
          state_nxt    = CLEAR;
          x0_nxt       = '0;
          x1_nxt       = X_MAX;
          y1_nxt       = Y_MAX;
          x_nxt        = '0;
          y_nxt        = '0;
          row_base_nxt = '0;
          solid_nxt    = 1'b0;
          we_nxt       = 1'b1;
          addr_nxt     = '0;
          busy_nxt     = 1'b1;
        end else if (accept) begin
          if (rect_empty) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = FILL;
            x0_nxt    = rect_x0;
            x1_nxt    = x1_clip;
            y1_nxt    = y1_clip;
            x_nxt     = rect_x0;
            y_nxt     = rect_y0;
            // Constant-stride multiply happens once per descriptor, not per pixel.
            row_base_nxt = ADDR_W'(rect_y0) * STRIDE;
            solid_nxt    = rect_solid;
            we_nxt       = 1'b1;
            addr_nxt     = row_base_nxt + ADDR_W'(rect_x0);
            din_nxt      = rect_solid;
            busy_nxt     = 1'b1;
          end
        end
      end

      CLEAR, FILL: begin
        if (last_cell) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          if (x_q == x1_q) begin
            x_nxt        = x0_q;
            y_nxt        = y_q + 10'd1;
            row_base_nxt = row_base_q + STRIDE;
          end else begin
            x_nxt = x_q + 10'd1;
          end
          we_nxt   = 1'b1;
          addr_nxt = row_base_nxt + ADDR_W'(x_nxt);
          din_nxt  = solid_q;
          busy_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (we_nxt && state_nxt == CLEAR) begin
`ifdef CMAP_BORDER_EN
      din_nxt = (x_nxt == '0) || (x_nxt == X_MAX) || (y_nxt == Y_MAX);
`else
      din_nxt = 1'b0;
`endif
    end
  end

  // State register and registered outputs; rst aborts any walk at the next edge.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      solid_q    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rect_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      x0_q       <= x0_nxt;
      x1_q       <= x1_nxt;
      y1_q       <= y1_nxt;
      x_q        <= x_nxt;
      y_q        <= y_nxt;
      row_base_q <= row_base_nxt;
      solid_q    <= solid_nxt;
      ram_we     <= we_nxt;
      ram_addr   <= addr_nxt;
      ram_din    <= din_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      rect_err   <= err_nxt;
    end
  end

endmodule
